uart_tx_arbiter: RTL

- Shares one UART transmitter among NREQ byte sources, e.g. the rx echo path, button-event messages and status reports.
- Grants requesters round-robin and latches the granted byte.
- Issues a single-cycle tx start pulse to the transmitter, then holds off until the transmitter reports frame end.
- Enforces an optional inter-frame idle gap.
- Sits between the application logic and the UART transmitter inputs (start, data, end), in the sysclk domain.

---
 rtl/uart_tx_arbiter_pkg.sv | 14 +
 rtl/uart_tx_arbiter_if.sv | 27 ++
 rtl/uart_tx_arbiter_rr_picker.sv | 40 ++++
 rtl/uart_tx_arbiter.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        GAP   = 2'd3
    } arb_state_e;

    localparam int          DW_DEFAULT      = 8;
    localparam logic [31:0] TIMEOUT_DEFAULT = 32'd2000000;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter side signals of the UART transmit arbiter.
interface uart_tx_arbiter_if
    import uart_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int DW   = DW_DEFAULT
);
    logic [NREQ-1:0]    req_valid_i;
    logic [NREQ*DW-1:0] req_data_i;
    logic [NREQ-1:0]    req_ready_o;
    logic               tx_start_o;
    logic [DW-1:0]      tx_data_o;
    logic               tx_end_i;
    logic [NREQ-1:0]    grant_o;
    logic               busy_o;
    logic               tx_timeout_o;

    modport slave (
        input  req_valid_i, req_data_i, tx_end_i,
        output req_ready_o, tx_start_o, tx_data_o, grant_o, busy_o, tx_timeout_o
    );

    modport master (
        output req_valid_i, req_data_i, tx_end_i,
        input  req_ready_o, tx_start_o, tx_data_o, grant_o, busy_o, tx_timeout_o
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first request after the last grant, wrapping.
module rr_picker
    import uart_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_last,
    output logic [NREQ-1:0] o_grant,
    output logic [IW-1:0]   o_idx
);

    int   w_pos;
    logic w_found;

    // Scan NREQ positions starting one past the last winner.
    always_comb begin
        o_grant = {NREQ{1'b0}};
        o_idx   = {IW{1'b0}};
        w_found = 1'b0;
        w_pos   = 0;
        for (int i = 1; i <= NREQ; i++) begin
            w_pos = int'(i_last) + i;
            if (w_pos >= NREQ) begin
                w_pos = w_pos - NREQ;
            end else begin
                w_pos = w_pos;
            end
            if (!w_found && i_req[w_pos]) begin
                w_found        = 1'b1;
                o_grant[w_pos] = 1'b1;
                o_idx          = IW'(w_pos);
            end else begin
                w_found = w_found;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte sources.
// Optional transmit watchdog enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int          NREQ       = 2,
    parameter int          DW         = DW_DEFAULT,
    parameter int          GAP_CYCLES = 0,
    parameter logic [31:0] TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic           sysclk,
    input  logic           reset_n,
    uart_tx_arbiter_if.slave bus
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e      r_state;
    arb_state_e      w_next_state;
    logic [IW-1:0]   r_last;
    logic            r_tx_start;
    logic [DW-1:0]   r_tx_data;
    logic [NREQ-1:0] r_grant;
    logic            r_busy;
    logic [31:0]     r_gap_cnt;

    logic [NREQ-1:0] w_pick_grant;
    logic [IW-1:0]   w_pick_idx;
    logic [NREQ-1:0] w_ready;
    logic            w_handshake;
    logic [DW-1:0]   w_sel_data;

`ifdef UART_TX_ARB_TIMEOUT_EN
    logic [31:0]     r_to_cnt;
    logic            r_timeout;
    logic            w_timeout_hit;
`endif

    rr_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_picker (
        .i_req   (bus.req_valid_i),
        .i_last  (r_last),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx)
    );

    // Ready only while idle; the picker only grants valid requesters.
    always_comb begin
        w_ready     = {NREQ{1'b0}};
        w_handshake = 1'b0;
        w_sel_data  = bus.req_data_i[int'(w_pick_idx)*DW +: DW];
        if (r_state == IDLE) begin
            w_ready     = w_pick_grant;
            w_handshake = |w_pick_grant;
        end else begin
            w_ready     = {NREQ{1'b0}};
            w_handshake = 1'b0;
        end
    end

    // Next-state logic; tx end wins over a coincident watchdog expiry.
    always_comb begin
        w_next_state = r_state;
`ifdef UART_TX_ARB_TIMEOUT_EN
        w_timeout_hit = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_handshake) begin
                    w_next_state = START;
                end else begin
                    w_next_state = IDLE;
                end
            end
            START: w_next_state = BUSY;
            BUSY: begin
                if (bus.tx_end_i) begin
                    w_next_state = (GAP_CYCLES > 0) ? GAP : IDLE;
                end
`ifdef UART_TX_ARB_TIMEOUT_EN
                else if (r_to_cnt == (TIMEOUT - 32'd1)) begin
                    w_timeout_hit = 1'b1;
                    w_next_state  = IDLE;
                end
`endif
                else begin
                    w_next_state = BUSY;
                end
            end
            GAP: begin
                if (r_gap_cnt == 32'd0) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = GAP;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State, frame ownership and registered transmitter outputs.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_last     <= IW'(NREQ - 1);
            r_tx_start <= 1'b0;
            r_tx_data  <= {DW{1'b0}};
            r_grant    <= {NREQ{1'b0}};
            r_busy     <= 1'b0;
            r_gap_cnt  <= 32'd0;
        end else begin
            r_state    <= w_next_state;
            r_tx_start <= (w_next_state == START);
            r_busy     <= (w_next_state != IDLE);
            if (w_handshake) begin
                r_tx_data <= w_sel_data;
                r_grant   <= w_pick_grant;
                r_last    <= w_pick_idx;
            end else if ((r_state == BUSY) && (w_next_state != BUSY)) begin
                r_grant <= {NREQ{1'b0}};
            end else begin
                r_grant <= r_grant;
            end
            // Load GAP_CYCLES-1 so the gap state lasts exactly GAP_CYCLES cycles.
            if ((r_state == BUSY) && (w_next_state == GAP)) begin
                r_gap_cnt <= 32'(GAP_CYCLES - 1);
            end else if ((r_state == GAP) && (r_gap_cnt != 32'd0)) begin
                r_gap_cnt <= r_gap_cnt - 32'd1;
            end else begin
                r_gap_cnt <= r_gap_cnt;
            end
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    // Watchdog counts BUSY cycles; the flag is sticky until reset.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            r_to_cnt  <= 32'd0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state == START) begin
                r_to_cnt <= 32'd0;
            end else if (r_state == BUSY) begin
                r_to_cnt <= r_to_cnt + 32'd1;
            end else begin
                r_to_cnt <= r_to_cnt;
            end
            r_timeout <= r_timeout | w_timeout_hit;
        end
    end

    assign bus.tx_timeout_o = r_timeout;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT;
    assign bus.tx_timeout_o = 1'b0;
`endif

    assign bus.req_ready_o = w_ready;
    assign bus.tx_start_o  = r_tx_start;
    assign bus.tx_data_o   = r_tx_data;
    assign bus.grant_o     = r_grant;
    assign bus.busy_o      = r_busy;

endmodule
